// File: rtl/ktc32_mem_pkg.sv
// Shared types and defaults for the KTC32 unified-memory arbiter.
package ktc32_mem_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} mem_owner_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int AW_DEF         = 32;

  // Width needed to hold a counter value in 0..max.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter: counts denied fetch cycles, flags when the limit is hit.
module arb_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified ram between instruction fetch and load/store.
// Data has priority, a starvation counter forces fetch progress, and d_lock holds
// the ram for the data port across read-modify-write sequences.
module mem_arbiter
  import ktc32_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wd,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = cnt_width(STARVE_MAX);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          starve_max;
  mem_owner_t    rsp_owner_p1;
  logic [31:0]   rdata_p1;

  arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (CW)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (i_req & ~i_gnt),
    .clr    (~i_req | i_gnt),
    .cnt    (starve_cnt),
    .at_max (starve_max)
  );

  // Grant decision and lock FSM next state; nothing is granted while in reset.
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (d_req && !(i_req && starve_max)) begin
            d_gnt = 1'b1;
          end else if (i_req) begin
            i_gnt = 1'b1;
          end
          if (d_gnt && d_lock) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // The release cycle itself still belongs to the data port.
          d_gnt = d_req;
          if (!d_lock) begin
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  assign mem_we   = d_gnt & d_we;
  assign mem_addr = i_gnt ? i_addr : d_addr;
  assign mem_wd   = d_wd;

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- p0 -> p1: capture ram read data and its owner on the grant edge ----
  // Store acks carry zero data; an ungranted cycle leaves no owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner_p1 <= OWN_NONE;
      rdata_p1     <= '0;
    end else if (i_gnt) begin
      rsp_owner_p1 <= OWN_I;
      rdata_p1     <= mem_rdata;
    end else if (d_gnt) begin
      rsp_owner_p1 <= OWN_D;
      rdata_p1     <= d_we ? 32'h0 : mem_rdata;
    end else begin
      rsp_owner_p1 <= OWN_NONE;
    end
  end

  assign i_rvalid = (rsp_owner_p1 == OWN_I);
  assign d_rvalid = (rsp_owner_p1 == OWN_D);
  assign i_rdata  = i_rvalid ? rdata_p1 : 32'h0;
  assign d_rdata  = d_rvalid ? rdata_p1 : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a small ram + LED MMIO model.
module tb_mem_arbiter;
  import ktc32_mem_pkg::*;

  localparam logic [31:0] WA = 32'h12345678;
  localparam logic [31:0] WB = 32'h11111111;
  localparam logic [31:0] WC = 32'h22222222;
  localparam logic [31:0] WD = 32'hDEADBEEF;
  localparam logic [31:0] MMIO = 32'hFFF00000;

  logic        clk, rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wd, d_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rdata;

  logic [31:0] ram [0:63];
  logic [3:0]  led;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    logic        dl;
    logic        e_ig, e_dg, e_we;
    logic [31:0] e_addr;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vq[$];

  mem_arbiter #(.STARVE_MAX(4), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wd      (d_wd),
    .d_lock    (d_lock),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ram model: combinational read, posedge write, LED register at the MMIO base.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) ram[k] <= 32'h0;
      ram[0] <= WA;
      ram[1] <= WB;
      ram[2] <= WC;
      led    <= 4'h0;
    end else if (mem_we) begin
      if (mem_addr[31:20] == 12'hFFF) led <= mem_wd[3:0];
      else if (mem_addr[31:8] == 24'h0) ram[mem_addr[7:2]] <= mem_wd;
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr[31:20] == 12'hFFF) mem_rdata = {28'h0, led};
    else if (mem_addr[31:8] == 24'h0) mem_rdata = ram[mem_addr[7:2]];
  end

  task automatic check(input string nm, input int v, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (v%0d): got %h, expected %h", nm, v, act, exp);
    end
  endtask

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                     input logic dl, input logic eig, input logic edg, input logic ewe,
                     input logic [31:0] eaddr, input logic eirv, input logic [31:0] eird,
                     input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dl = dl;
    v.e_ig = eig; v.e_dg = edg; v.e_we = ewe; v.e_addr = eaddr;
    v.e_irv = eirv; v.e_ird = eird; v.e_drv = edrv; v.e_drd = edrd;
    vq.push_back(v);
  endtask

  // Idle cycle: only the previous cycle's response is expected.
  task automatic idle(input logic eirv, input logic [31:0] eird,
                      input logic edrv, input logic [31:0] edrd);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eirv, eird, edrv, edrd);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic dl);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wd = dwd; d_lock = dl;
  endtask

  initial begin
    // Fetch only, word 0.
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, WA, 0, 0);
    // Store 0xDEADBEEF to 0x10, then load it back.
    add(0, 0, 1, 1, 32'h10, WD, 0, 0, 1, 1, 32'h10, 1, WA, 0, 0);
    add(0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0, 32'h10, 0, 0, 1, 0);
    idle(0, 0, 1, WD);
    idle(0, 0, 0, 0);
    // Contention for 10 cycles: d,d,d,d,i,d,d,d,d,i.
    for (int k = 0; k < 10; k++) begin
      logic is_i, prev_i, prev_d;
      is_i   = (k == 4) || (k == 9);
      prev_i = (k == 5);
      prev_d = (k > 0) && !prev_i;
      add(1, 32'h4, 1, 0, 32'h8, 0, 0, is_i, !is_i, 0, is_i ? 32'h4 : 32'h8,
          prev_i, prev_i ? WB : 32'h0, prev_d, prev_d ? WC : 32'h0);
    end
    idle(1, WB, 0, 0);
    // Lock held 8 grants with fetch pending, release, then starvation override.
    for (int k = 0; k < 8; k++)
      add(1, 32'h4, 1, 0, 32'h8, 0, 1, 0, 1, 0, 32'h8, 0, 0, k > 0, (k > 0) ? WC : 32'h0);
    add(1, 32'h4, 1, 0, 32'h8, 0, 0, 0, 1, 0, 32'h8, 0, 0, 1, WC);
    add(1, 32'h4, 1, 0, 32'h8, 0, 0, 1, 0, 0, 32'h4, 0, 0, 1, WC);
    idle(1, WB, 0, 0);
    // d_lock without a data grant must not lock.
    add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, WA, 0, 0);
    idle(1, WA, 0, 0);
    // MMIO store of 0x5 to the LED register.
    add(0, 0, 1, 1, MMIO, 32'h5, 0, 0, 1, 1, MMIO, 0, 0, 0, 0);
    idle(0, 0, 1, 0);
    // Fetch dropping its request clears the starvation count.
    add(1, 32'h4, 1, 0, 32'h8, 0, 0, 0, 1, 0, 32'h8, 0, 0, 0, 0);
    add(0, 32'h4, 1, 0, 32'h8, 0, 0, 0, 1, 0, 32'h8, 0, 0, 1, WC);
    for (int k = 0; k < 4; k++)
      add(1, 32'h4, 1, 0, 32'h8, 0, 0, 0, 1, 0, 32'h8, 0, 0, 1, WC);
    add(1, 32'h4, 1, 0, 32'h8, 0, 0, 1, 0, 0, 32'h4, 0, 0, 1, WC);
    idle(1, WB, 0, 0);

    // Reset state: requests asserted but nothing granted while rst_n is low.
    rst_n = 1'b0;
    drive(1, 0, 1, 1, 32'h10, WD, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_gnt", -1, 32'(i_gnt), 0);
    check("rst_d_gnt", -1, 32'(d_gnt), 0);
    check("rst_mem_we", -1, 32'(mem_we), 0);
    check("rst_i_rvalid", -1, 32'(i_rvalid), 0);
    check("rst_d_rvalid", -1, 32'(d_rvalid), 0);
    check("rst_i_rdata", -1, i_rdata, 0);
    check("rst_d_rdata", -1, d_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    for (int v = 0; v < vq.size(); v++) begin
      @(negedge clk);
      drive(vq[v].ir, vq[v].ia, vq[v].dr, vq[v].dwe, vq[v].da, vq[v].dwd, vq[v].dl);
      #1;
      check("i_gnt", v, 32'(i_gnt), 32'(vq[v].e_ig));
      check("d_gnt", v, 32'(d_gnt), 32'(vq[v].e_dg));
      check("mem_we", v, 32'(mem_we), 32'(vq[v].e_we));
      check("mem_addr", v, mem_addr, vq[v].e_addr);
      check("i_rvalid", v, 32'(i_rvalid), 32'(vq[v].e_irv));
      check("i_rdata", v, i_rdata, vq[v].e_ird);
      check("d_rvalid", v, 32'(d_rvalid), 32'(vq[v].e_drv));
      check("d_rdata", v, d_rdata, vq[v].e_drd);
      if (vq[v].dwe && vq[v].dr) check("mem_wd", v, mem_wd, vq[v].dwd);
    end
    check("mmio_led", -2, 32'(led), 32'h5);

    // Reset the cycle after a locking data grant with fetch pending.
    @(negedge clk);
    drive(1, 32'h4, 1, 0, 32'h8, 0, 1);
    #1;
    check("r6_d_gnt", -3, 32'(d_gnt), 1);
    @(posedge clk);
    #1;
    check("r6_locked", -3, 32'(dut.state), 32'(LOCKED));
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("r6_d_rvalid_rst", -3, 32'(d_rvalid), 0);
    check("r6_d_rdata_rst", -3, d_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("r6_d_rvalid_after", -3, 32'(d_rvalid), 0);
    end
    check("r6_state_arb", -3, 32'(dut.state), 32'(ARB));
    check("r6_starve_cnt", -3, 32'(dut.starve_cnt), 0);
    @(negedge clk);
    drive(1, 32'h4, 0, 0, 0, 0, 0);
    #1;
    check("r6_i_gnt", -3, 32'(i_gnt), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
